// File: rtl/bus_arbiter_mc.sv
// Shared broadcast-bus arbiter: grants one pending driver FIFO, pops its head packet,
// then pushes it to one destination, to every driver except the source, or drops it.
module bus_arbiter_mc #(
  parameter int pckg_sz = 16,
  parameter int drvrs = 4,
  parameter int id_sz = 8,
  parameter logic [id_sz-1:0] bcst_id = {id_sz{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  input  logic                       arb_mode,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic                       busy,
  output logic [15:0]                drop_cnt,
  output logic [1:0]                 state_dbg
);

  // Handshake: pop is a one-cycle strobe to the granted driver, which must keep
  // pndng high until that strobe; push is a one-cycle strobe with D_push valid
  // while any push bit is set. Neither side can stall the other.

  localparam int GW = $clog2(drvrs);
  localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, DELIVER = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        grant, grant_nxt;
  logic [GW-1:0]        last_grant, last_nxt;
  logic [GW-1:0]        winner;
  logic [drvrs-1:0]     pop_nxt, push_nxt, push_dec;
  logic [pckg_sz-1:0]   dpush_nxt, pop_pkt;
  logic [id_sz-1:0]     pop_id, pkt_id;
  logic [15:0]          drop_nxt;
  logic                 pkt_drop;
  int                   rr_idx;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Arbitration: descending scans so the highest-priority candidate is written last.
  always_comb begin
    winner = '0;
    rr_idx = 0;
    if (arb_mode) begin
      for (int i = drvrs - 1; i >= 0; i--)
        if (pndng[i]) winner = GW'(i);
    end else begin
      for (int k = drvrs; k >= 1; k--) begin
        rr_idx = (int'(last_grant) + k) % drvrs;
        if (pndng[rr_idx]) winner = GW'(rr_idx);
      end
    end
  end

  // Destination decode of the packet being popped; broadcast wins over a colliding unicast ID.
  always_comb begin
    pop_pkt = D_pop[int'(grant)*pckg_sz +: pckg_sz];
    pop_id  = pop_pkt[pckg_sz-1 -: id_sz];
    if (pop_id == bcst_id)
      push_dec = ~(ONE << grant);
    else if (32'(pop_id) < drvrs)
      push_dec = ONE << pop_id;
    else
      push_dec = '0;
  end

  // D_push doubles as the packet register, so the drop decision reads it back.
  assign pkt_id   = D_push[pckg_sz-1 -: id_sz];
  assign pkt_drop = (pkt_id != bcst_id) && !(32'(pkt_id) < drvrs);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    pop_nxt   = '0;
    push_nxt  = '0;
    dpush_nxt = D_push;
    drop_nxt  = drop_cnt;
    case (state)
      IDLE: begin
        if (|pndng) begin
          state_nxt = POP;
          grant_nxt = winner;
          last_nxt  = winner;
          pop_nxt   = ONE << winner;
        end
      end
      POP: begin
        state_nxt = DELIVER;
        push_nxt  = push_dec;
        dpush_nxt = pop_pkt;
      end
      DELIVER: begin
        state_nxt = IDLE;
        if (pkt_drop && (drop_cnt != 16'hFFFF)) drop_nxt = drop_cnt + 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(drvrs - 1);
      pop        <= '0;
      push       <= '0;
      D_push     <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
      pop        <= pop_nxt;
      push       <= push_nxt;
      D_push     <= dpush_nxt;
      drop_cnt   <= drop_nxt;
    end
  end

endmodule

// File: doc/bus_arbiter_mc.md
# bus_arbiter_mc

Parametrised successor to the bus generator/arbiter. It connects `drvrs` driver FIFOs to one shared broadcast bus. Each cycle of arbitration picks one pending driver, pops its head packet, decodes the destination ID from the packet header, and pushes the packet to one destination, to all drivers (broadcast), or drops it when the ID is invalid. New over the previous generation:

- runtime-selectable round-robin or fixed-priority arbitration;
- parametrised ID field and broadcast ID;
- source exclusion on broadcast;
- a saturating drop counter and a busy flag.

## Interface
Parameters:
- `pckg_sz`, default 16: packet width in bits; must be ≥ `id_sz` + 1.
- `drvrs`, default 4: number of drivers attached to the bus, 2..32.
- `id_sz`, default 8: width of the destination-ID field, located in `D[pckg_sz-1 -: id_sz]`.
- `bcst_id`, default `{id_sz{1'b1}}`: broadcast destination ID.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `pndng` in `drvrs`: bit i is high when driver i's output FIFO is non-empty.
- `D_pop` in `drvrs*pckg_sz`: head packet of each driver FIFO, first-word-fall-through; driver i is at `[i*pckg_sz +: pckg_sz]`.
- `arb_mode` in 1: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `pop` out `drvrs`: one-hot, single-cycle pop strobe to the granted driver.
- `push` out `drvrs`: push strobe to destination driver(s).
- `D_push` out `pckg_sz`: packet on the shared bus, valid while any `push` bit is high.
- `busy` out 1: high in any state other than IDLE.
- `drop_cnt` out 16: count of dropped packets; saturates at 16'hFFFF.

## Operation
FSM states: IDLE, POP, DELIVER.

- **IDLE**
  - If `pndng` is 0: stay in IDLE.
  - Otherwise select a winner `g` and register it, then go to POP.
  - `arb_mode` is sampled only in IDLE.
  - Round-robin: search starts at `last_grant+1` and wraps modulo `drvrs`. The first set `pndng` bit wins and `last_grant` is updated to `g`.
  - Fixed priority: the lowest set index wins; `last_grant` is still updated.
- **POP**
  - Assert `pop[g]` for exactly one cycle.
  - At that rising edge, capture `D_pop[g]` into the packet register.
  - Go to DELIVER.
  - The pop is issued even if `pndng[g]` fell after the grant. Drivers must hold `pndng` until popped.
- **DELIVER**
  - `D_push` = packet register. Decode `id = pkt[pckg_sz-1 -: id_sz]`:
    - `id == bcst_id`: `push` = all ones except bit `g`.
    - `id < drvrs`: `push` = one-hot bit `id`. Self-addressing (`id == g`) is delivered normally.
    - Otherwise: `push` = 0 and `drop_cnt` increments by 1, saturating.
  - Return to IDLE next cycle.
- **Registers**: `pop`, `push` and `D_push` are registered outputs, never combinational from inputs.
- **Reset** (asserted low, any state, asynchronous):
  - State → IDLE; `pop`, `push` = 0; `D_push` = 0; `busy` = 0; `drop_cnt` = 0.
  - `last_grant` = `drvrs-1`, so driver 0 wins the first round-robin grant.
  - A packet already popped but not yet delivered is lost and is not counted as a drop.
- **`bcst_id` collision**: if `bcst_id` < `drvrs`, broadcast takes precedence.

## Timing
- Cycle 0 (IDLE, `pndng` seen) → cycle 1 `pop[g]`=1 → cycle 2 `push`/`D_push` valid → cycle 3 IDLE, and a new grant may be made in that cycle.
- Throughput: one packet per 3 cycles under continuous `pndng`.
- Latency from the grant decision to `push`: 2 cycles.
- `pop` and `push` are each high for exactly one cycle per packet and are never high in the same cycle.
- `busy` is high during POP and DELIVER.
- `drop_cnt` updates on the edge leaving DELIVER, so it is visible in cycle 3.
- `pndng` changing during POP or DELIVER has no effect until the next IDLE.

## Test plan
Defaults for all scenarios: `drvrs`=4, `pckg_sz`=16, `id_sz`=8, `bcst_id`=8'hFF, `arb_mode`=0 unless stated.

- **Unicast**: driver 0 pending with 16'h02AB → `pop`=4'b0001 in cycle 1; `push`=4'b0100 and `D_push`=16'h02AB in cycle 2; `drop_cnt`=0.
- **Broadcast**: driver 1 pending with 16'hFF55 → `pop`=4'b0010; `push`=4'b1101 and `D_push`=16'hFF55.
- **Invalid ID**: driver 3 sends 16'h0711 → `push` stays 0; `drop_cnt`=1 in cycle 3. Force 65536 further drops → `drop_cnt` holds at 16'hFFFF.
- **Round-robin fairness**: `pndng`=4'b1111 held for 15 cycles → grant order 0,1,2,3,0, with pops spaced 3 cycles apart.
- **Fixed priority**: `arb_mode`=1, `pndng`=4'b1110 → grants 1,1,1. Drop `pndng[1]` → next grant is 2. Set `arb_mode`=0 while in DELIVER → the grant after that follows round-robin from `last_grant`.
- **Reset mid-operation**: assert `reset` low during POP → `pop`, `push`, `busy` and `drop_cnt` are 0 immediately, with no `push` pulse afterwards. Release `reset` with `pndng`=4'b1111 → first grant is driver 0.
